// File: rtl/dram_port_arbiter_pkg.sv
// Shared types for the data-RAM port arbiter: FSM state encoding, requester IDs
// and the priority pick used at arbitration time.
package dram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_CPU  = 1'b0,
    REQ_HOST = 1'b1
  } req_id_t;

  // Host wins only when it is alone or when it has been given priority for this round.
  function automatic req_id_t arb_pick(input logic cpu_req, input logic host_req,
                                       input logic host_pri);
    req_id_t w_id;
    if (host_req && (!cpu_req || host_pri)) begin
      w_id = REQ_HOST;
    end else begin
      w_id = REQ_CPU;
    end
    return w_id;
  endfunction

endpackage

// File: rtl/dram_port_arbiter_if.sv
// Requester and RAM-side signal bundle of dram_port_arbiter; the arbiter uses the
// slave modport, the requesters and RAM use the master modport.
interface dram_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  busy
  );

endinterface

// File: rtl/dpa_starve_cnt.sv
// Saturating count of arbitrations the host has lost in a row; o_hit tells the
// arbiter the host must win the next contested round.
module dpa_starve_cnt #(
  parameter int MAX = 4
) (
  input  logic clk1,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_hit
);
  localparam int CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_V = CW'(MAX);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= CW'(0);
    end else if (i_clr) begin
      r_cnt <= CW'(0);
    end else if (i_inc && (r_cnt != MAX_V)) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_hit = (r_cnt == MAX_V);

endmodule

// File: rtl/dram_port_arbiter.sv
// Arbitrates the single-ported data RAM between the CPU load/store path and the host
// loader port. Define DPA_ROUND_ROBIN_EN for alternating tie-break instead of CPU priority.
module dram_port_arbiter
  import dram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk1,
  input  logic                rst_n,
  dram_port_arbiter_if.slave  bus
);
  localparam logic [1:0] LAT_M1 = 2'(RAM_LAT - 1);

  arb_state_t        r_state, w_nxt_state;
  req_id_t           r_owner, w_win;
  logic              r_we;
  logic [1:0]        r_wait_cnt;
  logic              w_arb, w_host_pri, w_last_wait;

  logic              r_cpu_gnt, r_cpu_rvalid, r_host_gnt, r_host_rvalid;
  logic              r_ram_en, r_ram_we, r_busy;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata, r_cpu_rdata, r_host_rdata;

  logic              w_nxt_cpu_gnt, w_nxt_cpu_rvalid, w_nxt_host_gnt, w_nxt_host_rvalid;
  logic              w_nxt_ram_en, w_nxt_ram_we, w_nxt_busy;
  logic [ADDR_W-1:0] w_nxt_ram_addr;
  logic [DATA_W-1:0] w_nxt_ram_wdata, w_nxt_cpu_rdata, w_nxt_host_rdata;

  assign w_arb       = (r_state == IDLE) && (bus.cpu_req || bus.host_req);
  assign w_last_wait = (r_state == WAIT) && (r_wait_cnt == 2'd0);
  assign w_win       = arb_pick(bus.cpu_req, bus.host_req, w_host_pri);

`ifdef DPA_ROUND_ROBIN_EN
  logic r_cpu_last;

  assign w_host_pri = r_cpu_last;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_last <= 1'b0;
    end else if (w_arb) begin
      r_cpu_last <= (w_win == REQ_CPU);
    end else begin
      r_cpu_last <= r_cpu_last;
    end
  end
`else
  logic w_starve_inc, w_starve_clr;

  assign w_starve_inc = w_arb && bus.host_req && (w_win == REQ_CPU);
  assign w_starve_clr = (r_state == IDLE) && (!bus.host_req || (w_win == REQ_HOST));

  dpa_starve_cnt #(.MAX(STARVE_MAX)) u_starve_cnt (
    .clk1  (clk1),
    .rst_n (rst_n),
    .i_inc (w_starve_inc),
    .i_clr (w_starve_clr),
    .o_hit (w_host_pri)
  );
`endif

  // State register plus the access context latched at arbitration.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= REQ_CPU;
      r_we       <= 1'b0;
      r_wait_cnt <= 2'd0;
    end else begin
      r_state <= w_nxt_state;
      if (w_arb) begin
        r_owner <= w_win;
        r_we    <= (w_win == REQ_HOST) ? bus.host_we : bus.cpu_we;
      end
      if (r_state == ISSUE) begin
        r_wait_cnt <= LAT_M1;
      end else if ((r_state == WAIT) && (r_wait_cnt != 2'd0)) begin
        r_wait_cnt <= r_wait_cnt - 2'd1;
      end
    end
  end

  always_comb begin
    w_nxt_state = IDLE;
    case (r_state)
      IDLE:    w_nxt_state = w_arb ? ISSUE : IDLE;
      ISSUE:   w_nxt_state = r_we ? IDLE : WAIT;
      WAIT:    w_nxt_state = (r_wait_cnt == 2'd0) ? RESP : WAIT;
      RESP:    w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  // Next values of the registered outputs; only the owner's gnt/rvalid/rdata ever move.
  always_comb begin
    w_nxt_cpu_gnt     = 1'b0;
    w_nxt_host_gnt    = 1'b0;
    w_nxt_cpu_rvalid  = 1'b0;
    w_nxt_host_rvalid = 1'b0;
    w_nxt_ram_en      = 1'b0;
    w_nxt_ram_we      = 1'b0;
    w_nxt_ram_addr    = r_ram_addr;
    w_nxt_ram_wdata   = r_ram_wdata;
    w_nxt_cpu_rdata   = r_cpu_rdata;
    w_nxt_host_rdata  = r_host_rdata;
    w_nxt_busy        = (w_nxt_state != IDLE);
    if (w_arb) begin
      w_nxt_ram_en = 1'b1;
      if (w_win == REQ_HOST) begin
        w_nxt_host_gnt  = 1'b1;
        w_nxt_ram_we    = bus.host_we;
        w_nxt_ram_addr  = bus.host_addr;
        w_nxt_ram_wdata = bus.host_wdata;
      end else begin
        w_nxt_cpu_gnt   = 1'b1;
        w_nxt_ram_we    = bus.cpu_we;
        w_nxt_ram_addr  = bus.cpu_addr;
        w_nxt_ram_wdata = bus.cpu_wdata;
      end
    end else begin
      w_nxt_ram_en = 1'b0;
    end
    if (w_last_wait) begin
      if (r_owner == REQ_HOST) begin
        w_nxt_host_rvalid = 1'b1;
        w_nxt_host_rdata  = bus.ram_rdata;
      end else begin
        w_nxt_cpu_rvalid = 1'b1;
        w_nxt_cpu_rdata  = bus.ram_rdata;
      end
    end else begin
      w_nxt_cpu_rvalid = 1'b0;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_gnt     <= 1'b0;
      r_host_gnt    <= 1'b0;
      r_cpu_rvalid  <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_ram_en      <= 1'b0;
      r_ram_we      <= 1'b0;
      r_busy        <= 1'b0;
      r_ram_addr    <= {ADDR_W{1'b0}};
      r_ram_wdata   <= {DATA_W{1'b0}};
      r_cpu_rdata   <= {DATA_W{1'b0}};
      r_host_rdata  <= {DATA_W{1'b0}};
    end else begin
      r_cpu_gnt     <= w_nxt_cpu_gnt;
      r_host_gnt    <= w_nxt_host_gnt;
      r_cpu_rvalid  <= w_nxt_cpu_rvalid;
      r_host_rvalid <= w_nxt_host_rvalid;
      r_ram_en      <= w_nxt_ram_en;
      r_ram_we      <= w_nxt_ram_we;
      r_busy        <= w_nxt_busy;
      r_ram_addr    <= w_nxt_ram_addr;
      r_ram_wdata   <= w_nxt_ram_wdata;
      r_cpu_rdata   <= w_nxt_cpu_rdata;
      r_host_rdata  <= w_nxt_host_rdata;
    end
  end

  assign bus.cpu_gnt     = r_cpu_gnt;
  assign bus.cpu_rvalid  = r_cpu_rvalid;
  assign bus.cpu_rdata   = r_cpu_rdata;
  assign bus.host_gnt    = r_host_gnt;
  assign bus.host_rvalid = r_host_rvalid;
  assign bus.host_rdata  = r_host_rdata;
  assign bus.ram_en      = r_ram_en;
  assign bus.ram_we      = r_ram_we;
  assign bus.ram_addr    = r_ram_addr;
  assign bus.ram_wdata   = r_ram_wdata;
  assign bus.busy        = r_busy;

endmodule
